// File: rtl/pwr_seq_pkg.sv
// Shared types and codes for the power sequencer: state encoding, command
// and status bytes, timer width and the per-state rail enable map.
package pwr_seq_pkg;

    localparam int unsigned CNT_W = 20;

    localparam logic [7:0] CMD_DOWN  = 8'h00;
    localparam logic [7:0] CMD_UP    = 8'h01;

    localparam logic [7:0] STS_OFF   = 8'h00;
    localparam logic [7:0] STS_ON    = 8'h01;
    localparam logic [7:0] STS_FAULT = 8'hEE;

    typedef enum logic [3:0] {
        S_OFF,
        S_UP_VCORE,
        S_UP_VDIG,
        S_UP_PR,
        S_UP_FUNC,
        S_CHECK,
        S_ON,
        S_DN_FUNC,
        S_DN_PR,
        S_DN_VDIG,
        S_DN_VCORE,
        S_FAULT
    } seq_state_e;

    typedef struct packed {
        logic vcore;
        logic vdig;
        logic pr;
        logic func;
    } rail_en_t;

    // Entering UP_x enables item x; entering DN_x disables item x.
    function automatic rail_en_t rails_for(input seq_state_e s);
        rail_en_t r;
        r = '{1'b0, 1'b0, 1'b0, 1'b0};
        case (s)
            S_UP_VCORE, S_DN_VDIG:                r = '{1'b1, 1'b0, 1'b0, 1'b0};
            S_UP_VDIG, S_DN_PR:                   r = '{1'b1, 1'b1, 1'b0, 1'b0};
            S_UP_PR, S_DN_FUNC:                   r = '{1'b1, 1'b1, 1'b1, 1'b0};
            S_UP_FUNC, S_CHECK, S_ON, S_FAULT:    r = '{1'b1, 1'b1, 1'b1, 1'b1};
            default:                              r = '{1'b0, 1'b0, 1'b0, 1'b0};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/step_timer.sv
// Loadable saturating down-counter; done_c flags the last cycle of a loaded interval.
module step_timer
    import pwr_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic             done_c
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    // A load of N ends exactly N edges later; saturation at zero keeps this a single pulse.
    assign done_c = (count == CNT_W'(1));

endmodule

// File: rtl/pwr_sequencer.sv
// FPGA rail power sequencer with status reporting.
// Optional feature: define PWR_SEQ_PGOOD_CHECK_EN to enable the power-good check.
module pwr_sequencer
    import pwr_seq_pkg::*;
#(
    parameter int unsigned STEP_CYCLES   = 48000,
    parameter int unsigned PGOOD_TIMEOUT = 480000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    input  logic       sbis_power_on,
    output logic       off_vcore_fpga,
    output logic       off_vdigital_fpga,
    output logic       off_pr_digital_fpga,
    output logic       functional,
    output logic       have_msg,
    input  logic       rdreq,
    output logic [7:0] data_out,
    output logic [7:0] len
);

    seq_state_e       state, state_next;
    logic             cmd_up, cmd_dn;
    logic             done_c, load_c;
    logic [CNT_W-1:0] load_value_c;
    logic             post_c, post_q;
    logic [7:0]       post_code_c, post_code_q;
    rail_en_t         en_next;

`ifdef PWR_SEQ_PGOOD_CHECK_EN
    logic             low_q;
`else
    logic             unused_sbis;
    assign unused_sbis = sbis_power_on;
`endif

    assign cmd_up  = cmd_valid && (cmd_data == CMD_UP);
    assign cmd_dn  = cmd_valid && (cmd_data == CMD_DOWN);
    assign en_next = rails_for(state_next);
    assign len     = 8'd1;

    // Next state, status posting and timer reload.
    always_comb begin
        state_next   = state;
        post_c       = 1'b0;
        post_code_c  = STS_OFF;
        load_c       = 1'b0;
        load_value_c = '0;

        case (state)
            S_OFF: begin
                if (cmd_up) begin
                    state_next = S_UP_VCORE;
                end else if (cmd_dn) begin
                    post_c = 1'b1;
                end
            end
            S_UP_VCORE: begin
                if (cmd_dn)      state_next = S_DN_VCORE;
                else if (done_c) state_next = S_UP_VDIG;
            end
            S_UP_VDIG: begin
                if (cmd_dn)      state_next = S_DN_VDIG;
                else if (done_c) state_next = S_UP_PR;
            end
            S_UP_PR: begin
                if (cmd_dn)      state_next = S_DN_PR;
                else if (done_c) state_next = S_UP_FUNC;
            end
            S_UP_FUNC: begin
                if (cmd_dn) begin
                    state_next = S_DN_FUNC;
                end else if (done_c) begin
`ifdef PWR_SEQ_PGOOD_CHECK_EN
                    state_next = S_CHECK;
`else
                    state_next = S_ON;
`endif
                end
            end
`ifdef PWR_SEQ_PGOOD_CHECK_EN
            S_CHECK: begin
                if (cmd_dn)             state_next = S_DN_FUNC;
                else if (sbis_power_on) state_next = S_ON;
                else if (done_c)        state_next = S_FAULT;
            end
`endif
            S_ON: begin
                if (cmd_dn) begin
                    state_next = S_DN_FUNC;
                end
`ifdef PWR_SEQ_PGOOD_CHECK_EN
                else if (!sbis_power_on && low_q) begin
                    state_next = S_FAULT;
                end
`endif
            end
            S_FAULT:    state_next = S_DN_FUNC;
            S_DN_FUNC:  if (done_c) state_next = S_DN_PR;
            S_DN_PR:    if (done_c) state_next = S_DN_VDIG;
            S_DN_VDIG:  if (done_c) state_next = S_DN_VCORE;
            S_DN_VCORE: if (done_c) state_next = S_OFF;
            default:    state_next = S_OFF;
        endcase

        if (state_next != state) begin
            load_c = 1'b1;
            case (state_next)
                S_ON: begin
                    post_c      = 1'b1;
                    post_code_c = STS_ON;
                end
                S_OFF: begin
                    post_c      = 1'b1;
                    post_code_c = STS_OFF;
                end
                S_FAULT: begin
                    post_c      = 1'b1;
                    post_code_c = STS_FAULT;
                end
                default: ;
            endcase
            case (state_next)
                S_CHECK:             load_value_c = CNT_W'(PGOOD_TIMEOUT);
                S_OFF, S_ON, S_FAULT: load_value_c = '0;
                default:             load_value_c = CNT_W'(STEP_CYCLES);
            endcase
        end
    end

    // State and rail outputs; reset drops every rail at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= S_OFF;
            off_vcore_fpga      <= 1'b1;
            off_vdigital_fpga   <= 1'b1;
            off_pr_digital_fpga <= 1'b1;
            functional          <= 1'b0;
        end else begin
            state               <= state_next;
            off_vcore_fpga      <= !en_next.vcore;
            off_vdigital_fpga   <= !en_next.vdig;
            off_pr_digital_fpga <= !en_next.pr;
            functional          <= en_next.func;
        end
    end

    // Status lands one cycle after the posting edge and beats a coincident rdreq.
    always_ff @(posedge clk) begin
        if (rst) begin
            post_q      <= 1'b0;
            post_code_q <= STS_OFF;
            have_msg    <= 1'b0;
            data_out    <= STS_OFF;
        end else begin
            post_q      <= post_c;
            post_code_q <= post_code_c;
            if (post_q) begin
                have_msg <= 1'b1;
                data_out <= post_code_q;
            end else if (rdreq && have_msg) begin
                have_msg <= 1'b0;
            end
        end
    end

`ifdef PWR_SEQ_PGOOD_CHECK_EN
    // Remembers a low power-good sample from the previous ON cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            low_q <= 1'b0;
        end else begin
            low_q <= (state == S_ON) && !sbis_power_on;
        end
    end
`endif

    step_timer u_step_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (load_c),
        .load_value (load_value_c),
        .done_c     (done_c)
    );

endmodule

// File: tb/tb_pwr_sequencer.sv
// Testbench for pwr_sequencer: vector table, directed scenarios and a random run
// against a rail-level reference model. Honours PWR_SEQ_PGOOD_CHECK_EN.
module tb_pwr_sequencer;

    localparam int STEP = 4;
    localparam int TOUT = 16;
`ifdef PWR_SEQ_PGOOD_CHECK_EN
    localparam bit PG_EN = 1'b1;
`else
    localparam bit PG_EN = 1'b0;
`endif
    localparam int ON_CYC = PG_EN ? 18 : 17;

    localparam int MD_OFF = 0, MD_UP = 1, MD_CHK = 2, MD_ON = 3, MD_FLT = 4, MD_DN = 5;

    logic       clk = 1'b0;
    logic       rst, cmd_valid, sbis_power_on, rdreq;
    logic [7:0] cmd_data;
    logic       off_vcore_fpga, off_vdigital_fpga, off_pr_digital_fpga, functional, have_msg;
    logic [7:0] data_out, len;

    always #5 clk = ~clk;

    pwr_sequencer #(.STEP_CYCLES(STEP), .PGOOD_TIMEOUT(TOUT)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .cmd_data            (cmd_data),
        .cmd_valid           (cmd_valid),
        .sbis_power_on       (sbis_power_on),
        .off_vcore_fpga      (off_vcore_fpga),
        .off_vdigital_fpga   (off_vdigital_fpga),
        .off_pr_digital_fpga (off_pr_digital_fpga),
        .functional          (functional),
        .have_msg            (have_msg),
        .rdreq               (rdreq),
        .data_out            (data_out),
        .len                 (len)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit use_model = 1'b0;

    // Reference model: number of enabled items (0..4), phase, and time in phase.
    int         m_level = 0, m_mode = MD_OFF, m_age = 0, m_low = 0;
    bit         m_have = 1'b0, m_post = 1'b0;
    logic [7:0] m_data = 8'h00, m_post_code = 8'h00;

    typedef struct {
        logic       r;
        logic       cv;
        logic [7:0] cd;
        logic       rq;
        logic [2:0] exp_off;   // {vcore, vdigital, pr}
        logic       exp_func;
        logic       exp_have;
        logic [7:0] exp_data;
    } vec_t;

    vec_t tbl[22];

    function automatic vec_t mk(input logic r, input logic cv, input logic [7:0] cd, input logic rq,
                                input logic [2:0] eo, input logic ef, input logic eh, input logic [7:0] ed);
        vec_t v;
        v.r = r; v.cv = cv; v.cd = cd; v.rq = rq;
        v.exp_off = eo; v.exp_func = ef; v.exp_have = eh; v.exp_data = ed;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    endtask

    task automatic m_go(input int mode, input logic [7:0] code);
        m_mode = mode;
        m_age  = 0;
        m_low  = 0;
        if (mode == MD_ON || mode == MD_FLT || mode == MD_OFF) begin
            m_post      = 1'b1;
            m_post_code = code;
        end
    endtask

    task automatic model_step(input logic r, input logic cv, input logic [7:0] cd,
                              input logic sb, input logic rq);
        bit up, dn;
        if (r) begin
            m_level = 0; m_mode = MD_OFF; m_age = 0; m_low = 0;
            m_have = 1'b0; m_data = 8'h00; m_post = 1'b0;
            return;
        end
        if (m_post) begin
            m_have = 1'b1;
            m_data = m_post_code;
        end else if (rq && m_have) begin
            m_have = 1'b0;
        end
        m_post = 1'b0;
        up = cv && (cd == 8'h01);
        dn = cv && (cd == 8'h00);
        case (m_mode)
            MD_OFF: begin
                if (up) begin
                    m_level = 1; m_mode = MD_UP; m_age = 0;
                end else if (dn) begin
                    m_post = 1'b1; m_post_code = 8'h00;
                end
            end
            MD_UP: begin
                if (dn) begin
                    m_level = m_level - 1; m_go(MD_DN, 8'h00);
                end else if (m_age + 1 == STEP) begin
                    m_age = 0;
                    if (m_level < 4) m_level = m_level + 1;
                    else if (PG_EN) m_go(MD_CHK, 8'h00);
                    else m_go(MD_ON, 8'h01);
                end else m_age = m_age + 1;
            end
            MD_CHK: begin
                if (dn) begin
                    m_level = 3; m_go(MD_DN, 8'h00);
                end else if (sb) m_go(MD_ON, 8'h01);
                else if (m_age + 1 == TOUT) m_go(MD_FLT, 8'hEE);
                else m_age = m_age + 1;
            end
            MD_ON: begin
                if (dn) begin
                    m_level = 3; m_go(MD_DN, 8'h00);
                end else if (PG_EN) begin
                    if (sb) m_low = 0;
                    else if (m_low + 1 >= 2) m_go(MD_FLT, 8'hEE);
                    else m_low = m_low + 1;
                end
            end
            MD_FLT: begin
                m_level = 3; m_go(MD_DN, 8'h00);
            end
            default: begin
                if (m_age + 1 == STEP) begin
                    m_age = 0;
                    if (m_level == 0) m_go(MD_OFF, 8'h00);
                    else m_level = m_level - 1;
                end else m_age = m_age + 1;
            end
        endcase
    endtask

    task automatic compare_model();
        check("model off_vcore", 8'(off_vcore_fpga),      8'(m_level < 1));
        check("model off_vdig",  8'(off_vdigital_fpga),   8'(m_level < 2));
        check("model off_pr",    8'(off_pr_digital_fpga), 8'(m_level < 3));
        check("model functional", 8'(functional),         8'(m_level >= 4));
        check("model have_msg",  8'(have_msg),            8'(m_have));
        check("model data_out",  data_out,                m_data);
        check("model len",       len,                     8'd1);
    endtask

    task automatic tick(input logic r, input logic cv, input logic [7:0] cd,
                        input logic sb, input logic rq);
        rst = r; cmd_valid = cv; cmd_data = cd; sbis_power_on = sb; rdreq = rq;
        @(posedge clk);
        model_step(r, cv, cd, sb, rq);
        #1;
        if (use_model) compare_model();
    endtask

    // Power-up with an unread OFF status; rdreq coincides with the ON status latch.
    task automatic run_power_up(input logic sb);
        tick(1, 0, 8'h00, sb, 0);
        tick(0, 1, 8'h00, sb, 0);
        tick(0, 0, 8'h00, sb, 0);
        check("s1 old status pending", 8'(have_msg), 8'd1);
        tick(0, 1, 8'h01, sb, 0);
        check("s1 vcore on cycle1", 8'(off_vcore_fpga), 8'd0);
        for (int c = 2; c <= ON_CYC + 1; c++) begin
            tick(0, 0, 8'h00, sb, c == ON_CYC + 1);
            if (c == 4)  check("s1 vdig off cycle4", 8'(off_vdigital_fpga), 8'd1);
            if (c == 5)  check("s1 vdig on cycle5", 8'(off_vdigital_fpga), 8'd0);
            if (c == 8)  check("s1 pr off cycle8", 8'(off_pr_digital_fpga), 8'd1);
            if (c == 9)  check("s1 pr on cycle9", 8'(off_pr_digital_fpga), 8'd0);
            if (c == 12) check("s1 func off cycle12", 8'(functional), 8'd0);
            if (c == 13) check("s1 func on cycle13", 8'(functional), 8'd1);
            if (c == ON_CYC) check("s1 old data before ON", data_out, 8'h00);
            if (c == ON_CYC + 1) begin
                check("s5 have kept on collision", 8'(have_msg), 8'd1);
                check("s1 data ON", data_out, 8'h01);
            end
        end
        tick(0, 0, 8'h00, sb, 1);
        check("s5 rdreq clears", 8'(have_msg), 8'd0);
        tick(0, 1, 8'h5A, sb, 0);
        check("s5 0x5A no msg", 8'(have_msg), 8'd0);
        check("s5 0x5A func kept", 8'(functional), 8'd1);
    endtask

    // Power-up with power-good never asserting.
    task automatic run_no_pgood();
        tick(1, 0, 8'h00, 0, 0);
        tick(0, 1, 8'h01, 0, 0);
        for (int c = 2; c <= 52; c++) begin
            tick(0, 0, 8'h00, 0, 0);
`ifdef PWR_SEQ_PGOOD_CHECK_EN
            if (c == 33) begin
                check("s2 func in fault", 8'(functional), 8'd1);
                check("s2 no msg yet", 8'(have_msg), 8'd0);
            end
            if (c == 34) begin
                check("s2 fault status", data_out, 8'hEE);
                check("s2 fault have", 8'(have_msg), 8'd1);
                check("s2 func dropped", 8'(functional), 8'd0);
            end
            if (c == 37) check("s2 pr still on", 8'(off_pr_digital_fpga), 8'd0);
            if (c == 38) check("s2 pr off", 8'(off_pr_digital_fpga), 8'd1);
            if (c == 42) check("s2 vdig off", 8'(off_vdigital_fpga), 8'd1);
            if (c == 45) check("s2 vcore still on", 8'(off_vcore_fpga), 8'd0);
            if (c == 46) check("s2 vcore off", 8'(off_vcore_fpga), 8'd1);
            if (c == 50) check("s2 fault data held", data_out, 8'hEE);
            if (c == 51) check("s2 off status", data_out, 8'h00);
`else
            if (c == 17) check("s6 no msg at ON edge", 8'(have_msg), 8'd0);
            if (c == 18) begin
                check("s6 ON status", data_out, 8'h01);
                check("s6 ON have", 8'(have_msg), 8'd1);
            end
            if (c == 52) check("s6 stays on", 8'(functional), 8'd1);
`endif
        end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_data = 8'h00; sbis_power_on = 1'b1; rdreq = 1'b0;

        tbl[0]  = mk(1, 0, 8'h00, 0, 3'b111, 0, 0, 8'h00);
        tbl[1]  = mk(0, 1, 8'h5A, 0, 3'b111, 0, 0, 8'h00);
        tbl[2]  = mk(0, 1, 8'h00, 0, 3'b111, 0, 0, 8'h00);
        tbl[3]  = mk(0, 0, 8'h00, 0, 3'b111, 0, 1, 8'h00);
        tbl[4]  = mk(0, 0, 8'h00, 1, 3'b111, 0, 0, 8'h00);
        tbl[5]  = mk(0, 0, 8'h00, 1, 3'b111, 0, 0, 8'h00);
        tbl[6]  = mk(0, 1, 8'h01, 0, 3'b011, 0, 0, 8'h00);
        tbl[7]  = mk(0, 0, 8'h00, 0, 3'b011, 0, 0, 8'h00);
        tbl[8]  = mk(0, 0, 8'h00, 0, 3'b011, 0, 0, 8'h00);
        tbl[9]  = mk(0, 0, 8'h00, 0, 3'b011, 0, 0, 8'h00);
        tbl[10] = mk(0, 0, 8'h00, 0, 3'b001, 0, 0, 8'h00);
        tbl[11] = mk(0, 1, 8'h01, 0, 3'b001, 0, 0, 8'h00);
        tbl[12] = mk(0, 1, 8'h00, 0, 3'b011, 0, 0, 8'h00);
        tbl[13] = mk(0, 0, 8'h00, 0, 3'b011, 0, 0, 8'h00);
        tbl[14] = mk(0, 0, 8'h00, 0, 3'b011, 0, 0, 8'h00);
        tbl[15] = mk(0, 0, 8'h00, 0, 3'b011, 0, 0, 8'h00);
        tbl[16] = mk(0, 0, 8'h00, 0, 3'b111, 0, 0, 8'h00);
        tbl[17] = mk(0, 0, 8'h00, 0, 3'b111, 0, 0, 8'h00);
        tbl[18] = mk(0, 0, 8'h00, 0, 3'b111, 0, 0, 8'h00);
        tbl[19] = mk(0, 0, 8'h00, 0, 3'b111, 0, 0, 8'h00);
        tbl[20] = mk(0, 0, 8'h00, 0, 3'b111, 0, 0, 8'h00);
        tbl[21] = mk(0, 0, 8'h00, 0, 3'b111, 0, 1, 8'h00);

        @(negedge clk);
        use_model = 1'b0;
        for (int i = 0; i < 22; i++) begin
            tick(tbl[i].r, tbl[i].cv, tbl[i].cd, 1'b1, tbl[i].rq);
            check($sformatf("vec%0d off_rails", i),
                  8'({off_vcore_fpga, off_vdigital_fpga, off_pr_digital_fpga}), 8'(tbl[i].exp_off));
            check($sformatf("vec%0d functional", i), 8'(functional), 8'(tbl[i].exp_func));
            check($sformatf("vec%0d have_msg", i), 8'(have_msg), 8'(tbl[i].exp_have));
            check($sformatf("vec%0d data_out", i), data_out, tbl[i].exp_data);
        end

        use_model = 1'b1;
        run_power_up(1'b1);
`ifndef PWR_SEQ_PGOOD_CHECK_EN
        run_power_up(1'b0);
`endif
        run_no_pgood();

        // Reset in UP_PR with a pending status.
        tick(1, 0, 8'h00, 1, 0);
        tick(0, 1, 8'h00, 1, 0);
        tick(0, 0, 8'h00, 1, 0);
        tick(0, 1, 8'h01, 1, 0);
        for (int c = 2; c <= 10; c++) tick(0, 0, 8'h00, 1, 0);
        check("s4 in UP_PR", 8'(off_pr_digital_fpga), 8'd0);
        tick(1, 0, 8'h00, 1, 0);
        check("s4 rails off", 8'({off_vcore_fpga, off_vdigital_fpga, off_pr_digital_fpga}), 8'h07);
        check("s4 func off", 8'(functional), 8'd0);
        check("s4 have cleared", 8'(have_msg), 8'd0);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            logic       r, cv, sb, rq;
            logic [7:0] cd;
            int         sel;
            r   = ($urandom_range(0, 199) == 0);
            cv  = ($urandom_range(0, 19) == 0);
            sel = $urandom_range(0, 9);
            cd  = (sel < 5) ? 8'h01 : (sel < 7) ? 8'h00 : 8'($urandom);
            sb  = ($urandom_range(0, 7) != 0);
            rq  = ($urandom_range(0, 3) == 0);
            tick(r, cv, cd, sb, rq);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
